// File: rtl/packet_pkg.sv
// Shared switch types and sizes; the arbiter adds its port-index width,
// FSM state enum and per-output FSM record here.
package packet_pkg;
  localparam int NUM_PORTS  = 4;
  localparam int PORT_IDX_W = $clog2(NUM_PORTS);
  localparam int ADDR_WIDTH = NUM_PORTS;
  localparam int DATA_WIDTH = 32;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  typedef struct packed {
    arb_state_t            state;
    logic [PORT_IDX_W-1:0] owner;
    logic [PORT_IDX_W-1:0] ptr;
    logic [3:0]            beats;
  } arb_fsm_t;

  function automatic logic is_onehot(input logic [ADDR_WIDTH-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction
endpackage

// File: rtl/rr_burst_arbiter_if.sv
// Request/grant bundle between the switch ports, the arbiter and the output muxes.
interface rr_burst_arbiter_if #(parameter int STAT_WIDTH = 16);
  logic [packet_pkg::NUM_PORTS-1:0]  port_reqs;
  logic [packet_pkg::ADDR_WIDTH-1:0] port0_dst, port1_dst, port2_dst, port3_dst;
  logic                              stats_clr;
  logic [packet_pkg::NUM_PORTS-1:0]  grant_bus;
  logic [packet_pkg::PORT_IDX_W-1:0] mux_sel0, mux_sel1, mux_sel2, mux_sel3;
  logic                              active0, active1, active2, active3;
  logic [packet_pkg::NUM_PORTS-1:0]  dst_err;
  logic [STAT_WIDTH-1:0]             grant_cnt0, grant_cnt1, grant_cnt2, grant_cnt3;

  modport master (
    output port_reqs, port0_dst, port1_dst, port2_dst, port3_dst, stats_clr,
    input  grant_bus, mux_sel0, mux_sel1, mux_sel2, mux_sel3,
           active0, active1, active2, active3, dst_err,
           grant_cnt0, grant_cnt1, grant_cnt2, grant_cnt3
  );

  modport slave (
    input  port_reqs, port0_dst, port1_dst, port2_dst, port3_dst, stats_clr,
    output grant_bus, mux_sel0, mux_sel1, mux_sel2, mux_sel3,
           active0, active1, active2, active3, dst_err,
           grant_cnt0, grant_cnt1, grant_cnt2, grant_cnt3
  );
endinterface

// File: rtl/rr_burst_arbiter_pick.sv
// Combinational 4-way rotating-priority picker: first set req bit scanning
// from ptr upward, modulo NUM_PORTS.
module rr_pick
  import packet_pkg::*;
(
  input  logic [NUM_PORTS-1:0]  req,
  input  logic [PORT_IDX_W-1:0] ptr,
  output logic                  valid,
  output logic [PORT_IDX_W-1:0] idx
);
  logic [PORT_IDX_W-1:0] cand;

  // Scan from farthest to nearest so the candidate closest to ptr wins.
  always_comb begin
    cand  = '0;
    idx   = ptr;
    valid = |req;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      cand = PORT_IDX_W'(ptr + k);
      if (req[cand]) idx = cand;
    end
  end
endmodule

// File: rtl/rr_burst_arbiter.sv
// Per-output round-robin arbiter with bounded burst ownership (MAX_BURST beats).
// Optional beat counters are built when ARB_STATS_EN is defined.
module rr_burst_arbiter
  import packet_pkg::*;
#(
  parameter int MAX_BURST  = 4,
  parameter int STAT_WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  rr_burst_arbiter_if.slave bus
);
  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] dst;
  logic [NUM_PORTS-1:0]                 req_live, dst_ok, grant;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]  r_o;      // [output][input]
  logic [NUM_PORTS-1:0]                 own_req, active, release_now, pick_vld;
  logic [NUM_PORTS-1:0][PORT_IDX_W-1:0] pick_ptr, pick_idx;
  logic [NUM_PORTS-1:0][STAT_WIDTH-1:0] cnt_q;
  arb_fsm_t                             fsm_q [NUM_PORTS];
  arb_fsm_t                             fsm_d [NUM_PORTS];

  assign dst      = {bus.port3_dst, bus.port2_dst, bus.port1_dst, bus.port0_dst};
  assign req_live = bus.port_reqs & {NUM_PORTS{rst_n}};

  always_comb begin
    dst_ok      = '0;
    r_o         = '0;
    own_req     = '0;
    active      = '0;
    release_now = '0;
    pick_ptr    = '0;
    for (int i = 0; i < NUM_PORTS; i++) dst_ok[i] = is_onehot(dst[i]);
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++)
        r_o[o][i] = req_live[i] & dst[i][o] & dst_ok[i];
      own_req[o]     = r_o[o][fsm_q[o].owner];
      active[o]      = (fsm_q[o].state == ARB_BUSY) & own_req[o];
      release_now[o] = (fsm_q[o].state == ARB_BUSY) &
                       (!own_req[o] || fsm_q[o].beats == LAST_BEAT);
      // A releasing output re-arbitrates this cycle from just past the old owner.
      pick_ptr[o]    = release_now[o] ? PORT_IDX_W'(fsm_q[o].owner + 1'b1)
                                      : fsm_q[o].ptr;
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_pick
    rr_pick u_pick (
      .req   (r_o[o]),
      .ptr   (pick_ptr[o]),
      .valid (pick_vld[o]),
      .idx   (pick_idx[o])
    );
  end

  always_comb begin
    grant = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      fsm_d[o] = fsm_q[o];
      if (active[o]) grant[fsm_q[o].owner] = 1'b1;
      case (fsm_q[o].state)
        ARB_IDLE: begin
          if (pick_vld[o]) begin
            fsm_d[o].state = ARB_BUSY;
            fsm_d[o].owner = pick_idx[o];
            fsm_d[o].beats = '0;
          end
        end
        ARB_BUSY: begin
          if (release_now[o]) begin
            fsm_d[o].ptr = pick_ptr[o];
            if (pick_vld[o]) begin
              fsm_d[o].owner = pick_idx[o];
              fsm_d[o].beats = '0;
            end else begin
              fsm_d[o].state = ARB_IDLE;
            end
          end else begin
            fsm_d[o].beats = 4'(fsm_q[o].beats + 1'b1);
          end
        end
        default: fsm_d[o].state = ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < NUM_PORTS; o++)
        fsm_q[o] <= '{state: ARB_IDLE, owner: '0, ptr: '0, beats: '0};
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) fsm_q[o] <= fsm_d[o];
    end
  end

`ifdef ARB_STATS_EN
  logic [NUM_PORTS-1:0][STAT_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (bus.stats_clr)                 cnt_d[o] = '0;
      else if (active[o] && ~&cnt_q[o])  cnt_d[o] = cnt_q[o] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_stats_clr;
  assign unused_stats_clr = bus.stats_clr;
  assign cnt_q            = '0;
`endif

  assign bus.grant_bus  = grant;
  assign bus.dst_err    = req_live & ~dst_ok;
  assign bus.active0    = active[0];
  assign bus.active1    = active[1];
  assign bus.active2    = active[2];
  assign bus.active3    = active[3];
  assign bus.mux_sel0   = fsm_q[0].owner;
  assign bus.mux_sel1   = fsm_q[1].owner;
  assign bus.mux_sel2   = fsm_q[2].owner;
  assign bus.mux_sel3   = fsm_q[3].owner;
  assign bus.grant_cnt0 = cnt_q[0];
  assign bus.grant_cnt1 = cnt_q[1];
  assign bus.grant_cnt2 = cnt_q[2];
  assign bus.grant_cnt3 = cnt_q[3];
endmodule

// File: doc/rr_burst_arbiter.md
# rr_burst_arbiter

Per-output round-robin arbiter with bounded burst ownership for the 4-port packet switch. It sits between the four `switch_port` instances and the four `output_mux` instances. It collects each input's request and one-hot destination, and gives each output port a fair, work-conserving owner. The owner may hold an output for at most `MAX_BURST` consecutive beats. The block drives the per-input FIFO pop grants and the per-output mux select and valid enables.

## Interface
- `MAX_BURST`, default 4: maximum consecutive beats one input may own an output; legal range 1..15.
- `STAT_WIDTH`, default 16: width of the per-output beat counters.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `port_reqs` in 4: bit i = input i has a head-of-FIFO beat.
- `port0_dst`..`port3_dst` in 4 each: one-hot destination of input i's head beat (`ADDR_WIDTH`).
- `stats_clr` in 1: synchronous clear of the beat counters.
- `grant_bus` out 4: bit i = pop input i's FIFO this cycle.
- `mux_sel0`..`mux_sel3` out 2 each: source input index for output o.
- `active0`..`active3` out 1 each: output o carries a valid beat this cycle.
- `dst_err` out 4: bit i = input i requested with a non-one-hot destination this cycle.
- `grant_cnt0`..`grant_cnt3` out `STAT_WIDTH` each: beats delivered per output.

## Operation
- Per-output request vector: r_o[i] = `port_reqs`[i] & `portI_dst`[o] & onehot(`portI_dst`).
- A destination of zero, or with 2 or more bits set, is never routed. Such a request raises `dst_err`[i] combinationally for every cycle it is present.
- Each output o has a registered FSM: IDLE or BUSY. Each FSM also holds:
  - `owner` (2 b)
  - `ptr` (2 b, rotating priority start)
  - `beats` (4 b)
- Pick rule: the first i with r_o[i]=1, scanning `ptr`, `ptr`+1, … modulo 4.
- IDLE:
  - If any r_o is set, go to BUSY at the next edge, with `owner`=pick and `beats`=0.
  - Otherwise stay in IDLE.
- BUSY, beat condition: a beat occurs in a cycle when r_o[owner]=1. In that cycle, `beats` increments.
- BUSY, release conditions: release happens at the edge ending a cycle in which either:
  - r_o[owner]=0, or
  - a beat occurs with `beats`=`MAX_BURST`-1.
- On release:
  - `ptr` becomes `owner`+1 (wraps 3→0).
  - The FSM re-arbitrates in the same cycle using the new pointer over the current r_o.
  - If there is a winner, it stays BUSY with the new owner and `beats`=0, so there is no bubble.
  - If there is no winner, it goes to IDLE.
- A former owner is re-picked only if no other input requests that output.
- Outputs, all combinational from registered state and live requests:
  - `active`o = BUSY & r_o[owner]
  - `mux_sel`o = `owner`
  - `grant_bus`[i] = OR over o of (`active`o & `owner`o==i)
- Because destinations are one-hot, at most one output can grant a given input in any cycle.
- `grant_cnt`o increments by 1 on every cycle with `active`o=1 and saturates at all-ones. `stats_clr` has priority over increment.

## Timing
- Reset values: FSMs IDLE, `ptr`=0, `owner`=0, `beats`=0.
- Outputs during reset: `grant_bus`=0, `mux_sel`*=0, `active`*=0, `dst_err`=0 (`port_reqs` gated by reset), `grant_cnt`*=0.
- Latency: a request first present in cycle t produces a grant no earlier than cycle t+1.
- Back-to-back owners have zero idle cycles between them.
- Handshake:
  - `grant_bus`[i] high means the FIFO pops at that edge.
  - An input dropping `port_reqs` loses the grant in the same cycle, so there is never a pop from an empty FIFO.
- A destination change on the owner's head beat is treated as r_o[owner]=0 and causes release.
- `MAX_BURST`=1 gives strict per-beat round-robin.
- Reset asserted mid-burst clears all state immediately. No grant is issued while `rst_n`=0.

## Configuration
- `ARB_STATS_EN` defined: the `grant_cnt` counters and `stats_clr` logic are built.
- `ARB_STATS_EN` undefined: the ports stay present, `grant_cnt`* are tied to 0, and `stats_clr` is ignored.

## Structure
- `packet_pkg` gains:
  - `NUM_PORTS`=4
  - `PORT_IDX_W`=$clog2(`NUM_PORTS`)
  - enum `arb_state_t` {ARB_IDLE, ARB_BUSY}
- `ADDR_WIDTH` and `DATA_WIDTH` are reused from `packet_pkg`.
- Sub-module `rr_pick`: combinational 4-way rotating-priority picker (req, ptr → valid, idx), instantiated once per output. The FSM, counters and output logic stay in `rr_burst_arbiter`.

## Test plan
- Input 2 requests dst 4'b0001 for one beat → `active0`=1 and `mux_sel0`=2 on the cycle after the request; `grant_bus`=4'b0100 for exactly 1 cycle.
- Inputs 0, 1 and 3 continuously request output 2 with `MAX_BURST`=4 → owners 0,0,0,0,1,1,1,1,3,3,3,3,0… with no gap cycles.
- Input 1 requests output 3 for 2 beats, then drops while input 0 waits → 2 grants to 1, then input 0 owns output 3 on the next cycle; `grant_bus`[1] is never high without `port_reqs`[1].
- Inputs 0→1, 1→0, 2→3 and 3→2 all requesting → all four outputs active simultaneously; `grant_bus`=4'hF.
- Input 3 requests dst 4'b0110 → `dst_err`[3]=1, no output is activated, and `grant_bus`[3]=0.
- With `ARB_STATS_EN`: after 10 beats on output 1, `grant_cnt1`=10; pulsing `stats_clr` during a beat gives 0. Asserting `rst_n`=0 mid-burst forces all outputs to 0 asynchronously.
